// File: rtl/sipo_deserializer_if.sv
// Parallel-side bundle for the serial receiver: serial bit strobe inputs,
// the word valid/ready handshake and the status flags.
interface sipo_deserializer_if #(parameter int WIDTH = 8);
    logic             serial_in;
    logic             bit_en;
    logic             frame_start;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             overrun;
    logic             frame_err;
    logic             clear_err;

    modport slave (
        input  serial_in, bit_en, frame_start, out_ready, clear_err,
        output out_data, out_valid, busy, overrun, frame_err
    );

    modport master (
        output serial_in, bit_en, frame_start, out_ready, clear_err,
        input  out_data, out_valid, busy, overrun, frame_err
    );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel receiver: hunts for a frame marker, assembles WIDTH-bit
// words and offers them on a valid/ready port with sticky overrun/framing flags.
module sipo_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    sipo_deserializer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {HUNT, SHIFT} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;
    logic             word_done, frame_set;

    function automatic logic [WIDTH-1:0] ins(input logic [WIDTH-1:0] v, input logic b);
        if (MSB_FIRST) return {v[WIDTH-2:0], b};
        else           return {b, v[WIDTH-1:1]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            count_q     <= '0;
            shift_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            shift_q     <= shift_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // A frame marker always restarts from an empty register so a discarded
    // partial word can never leak bits into the next one.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        shift_d   = shift_q;
        word_done = 1'b0;
        frame_set = 1'b0;
        if (bus.bit_en) begin
            if (bus.frame_start) begin
                state_d   = SHIFT;
                count_d   = CW'(1);
                shift_d   = ins('0, bus.serial_in);
                frame_set = (state_q == SHIFT) && (count_q != '0);
            end else if (state_q == SHIFT) begin
                shift_d = ins(shift_q, bus.serial_in);
                if (count_q == LAST) begin
                    count_d   = '0;
                    word_done = 1'b1;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q && !bus.clear_err;
        frame_err_d = (frame_err_q && !bus.clear_err) || frame_set;
        busy_d      = (state_d == SHIFT) && (count_d != '0);
        if (word_done) begin
            if (!out_valid_q || bus.out_ready) begin
                out_data_d  = shift_d;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench: an MSB-first and an LSB-first receiver share one stimulus
// stream; handshakes are logged per instance and checked against fixed words.
module tb_sipo_deserializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    sipo_deserializer_if #(.WIDTH(8)) im ();
    sipo_deserializer_if #(.WIDTH(8)) il ();

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(im.slave));
    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(il.slave));

    always #5 clk = ~clk;

    logic [7:0] mwords [16];
    logic [7:0] lwords [16];
    int mcnt = 0;
    int lcnt = 0;

    always @(posedge clk) begin
        if (im.out_valid && im.out_ready) begin
            mwords[mcnt % 16] = im.out_data;
            mcnt++;
        end
        if (il.out_valid && il.out_ready) begin
            lwords[lcnt % 16] = il.out_data;
            lcnt++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_ready(input logic r);
        im.out_ready = r; il.out_ready = r;
    endtask

    task automatic set_clear(input logic c);
        im.clear_err = c; il.clear_err = c;
    endtask

    task automatic bit_cycle(input logic b, input logic fs);
        im.serial_in = b;  il.serial_in = b;
        im.bit_en = 1'b1;  il.bit_en = 1'b1;
        im.frame_start = fs; il.frame_start = fs;
        @(posedge clk); #1;
        im.bit_en = 1'b0;  il.bit_en = 1'b0;
        im.frame_start = 1'b0; il.frame_start = 1'b0;
    endtask

    // Bits go out w[7] first; gap inserts one idle cycle after every bit.
    task automatic send_word(input logic [7:0] w, input logic fs, input logic gap);
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(w[i], fs && (i == 7));
            if (gap) idle(1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        mcnt = 0; lcnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        checks++; if (im.out_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", im.out_data); end
        checks++; if (im.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", im.out_valid); end
        checks++; if (im.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", im.busy); end
        checks++; if ({im.overrun, im.frame_err} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {im.overrun, im.frame_err}); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] w;
        do_reset();
        set_ready(1'b1);
        w = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(w[i], i == 7);
            if (i > 0) begin
                checks++; if (im.busy !== 1'b1 || im.out_valid !== 1'b0) begin failures++;
                    $display("FAIL basic_busy bit%0d got busy=%b valid=%b exp busy=1 valid=0", 8 - i, im.busy, im.out_valid); end
            end
        end
        checks++; if (im.out_valid !== 1'b1 || im.out_data !== 8'hA5) begin failures++;
            $display("FAIL basic_word got valid=%b data=%h exp valid=1 data=a5", im.out_valid, im.out_data); end
        checks++; if (im.busy !== 1'b0) begin failures++; $display("FAIL basic_busy_end got=%b exp=0", im.busy); end
        idle(1);
        checks++; if (im.out_valid !== 1'b0 || im.out_data !== 8'hA5) begin failures++;
            $display("FAIL basic_pulse got valid=%b data=%h exp valid=0 data=a5", im.out_valid, im.out_data); end
        idle(2);
        checks++; if (mcnt !== 1) begin failures++; $display("FAIL basic_count got=%0d exp=1", mcnt); end
    endtask

    task automatic test_gaps();
        do_reset();
        set_ready(1'b1);
        send_word(8'h3C, 1'b1, 1'b1);
        send_word(8'hC3, 1'b0, 1'b1);
        idle(3);
        checks++; if (mcnt !== 2) begin failures++; $display("FAIL gaps_count got=%0d exp=2", mcnt); end
        checks++; if (mwords[0] !== 8'h3C || mwords[1] !== 8'hC3) begin failures++;
            $display("FAIL gaps_words got=%h,%h exp=3c,c3", mwords[0], mwords[1]); end
        checks++; if ({im.overrun, im.frame_err} !== 2'b00) begin failures++; $display("FAIL gaps_flags got=%b exp=00", {im.overrun, im.frame_err}); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_ready(1'b1);
        send_word(8'h96, 1'b1, 1'b0);
        send_word(8'h0F, 1'b0, 1'b0);
        checks++; if (im.out_valid !== 1'b1 || im.out_data !== 8'h0F || im.busy !== 1'b0) begin failures++;
            $display("FAIL b2b_second got valid=%b data=%h busy=%b exp 1/0f/0", im.out_valid, im.out_data, im.busy); end
        idle(2);
        checks++; if (mcnt !== 2 || mwords[0] !== 8'h96 || mwords[1] !== 8'h0F) begin failures++;
            $display("FAIL b2b_words got n=%0d %h,%h exp n=2 96,0f", mcnt, mwords[0], mwords[1]); end
    endtask

    task automatic test_lsb_first();
        do_reset();
        set_ready(1'b1);
        send_word(8'hA5, 1'b1, 1'b0);
        idle(1);
        send_word(8'h01, 1'b0, 1'b0);
        idle(2);
        checks++; if (lcnt !== 2 || lwords[0] !== 8'hA5 || lwords[1] !== 8'h80) begin failures++;
            $display("FAIL lsb_words got n=%0d %h,%h exp n=2 a5,80", lcnt, lwords[0], lwords[1]); end
        checks++; if (mwords[1] !== 8'h01) begin failures++; $display("FAIL lsb_msb_ref got=%h exp=01", mwords[1]); end
    endtask

    task automatic test_overrun();
        logic [7:0] w;
        do_reset();
        set_ready(1'b0);
        send_word(8'h11, 1'b1, 1'b0);
        send_word(8'h22, 1'b0, 1'b0);
        checks++; if (im.out_valid !== 1'b1 || im.out_data !== 8'h11 || im.overrun !== 1'b1) begin failures++;
            $display("FAIL ovr_hold got valid=%b data=%h ovr=%b exp 1/11/1", im.out_valid, im.out_data, im.overrun); end
        set_ready(1'b1);
        idle(1);
        checks++; if (im.out_valid !== 1'b0 || im.out_data !== 8'h11 || mcnt !== 1 || mwords[0] !== 8'h11) begin failures++;
            $display("FAIL ovr_accept got valid=%b data=%h n=%0d exp 0/11/1", im.out_valid, im.out_data, mcnt); end
        checks++; if (im.overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", im.overrun); end
        set_clear(1'b1);
        idle(1);
        set_clear(1'b0);
        checks++; if (im.overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", im.overrun); end
        // accept and reload on the same edge
        mcnt = 0;
        set_ready(1'b0);
        send_word(8'h33, 1'b0, 1'b0);
        w = 8'h44;
        for (int i = 7; i >= 1; i--) bit_cycle(w[i], 1'b0);
        set_ready(1'b1);
        bit_cycle(w[0], 1'b0);
        checks++; if (im.out_valid !== 1'b1 || im.out_data !== 8'h44 || im.overrun !== 1'b0) begin failures++;
            $display("FAIL reload got valid=%b data=%h ovr=%b exp 1/44/0", im.out_valid, im.out_data, im.overrun); end
        idle(2);
        checks++; if (mcnt !== 2 || mwords[0] !== 8'h33 || mwords[1] !== 8'h44) begin failures++;
            $display("FAIL reload_words got n=%0d %h,%h exp n=2 33,44", mcnt, mwords[0], mwords[1]); end
    endtask

    task automatic test_resync();
        do_reset();
        set_ready(1'b1);
        send_word(8'hFF, 1'b0, 1'b0);
        idle(2);
        checks++; if (mcnt !== 0 || im.busy !== 1'b0 || im.out_valid !== 1'b0) begin failures++;
            $display("FAIL hunt_ignore got n=%0d busy=%b valid=%b exp 0/0/0", mcnt, im.busy, im.out_valid); end
        bit_cycle(1'b1, 1'b1);
        bit_cycle(1'b1, 1'b0);
        bit_cycle(1'b1, 1'b0);
        send_word(8'h5A, 1'b1, 1'b0);
        checks++; if (im.frame_err !== 1'b1 || im.out_data !== 8'h5A || im.out_valid !== 1'b1) begin failures++;
            $display("FAIL resync got ferr=%b data=%h valid=%b exp 1/5a/1", im.frame_err, im.out_data, im.out_valid); end
        idle(2);
        checks++; if (mcnt !== 1 || mwords[0] !== 8'h5A) begin failures++;
            $display("FAIL resync_words got n=%0d %h exp n=1 5a", mcnt, mwords[0]); end
        set_clear(1'b1);
        idle(1);
        checks++; if (im.frame_err !== 1'b0) begin failures++; $display("FAIL ferr_clear got=%b exp=0", im.frame_err); end
        // a framing error on the same edge as clear_err must stay set
        set_clear(1'b0);
        bit_cycle(1'b0, 1'b1);
        bit_cycle(1'b0, 1'b0);
        set_clear(1'b1);
        bit_cycle(1'b1, 1'b1);
        set_clear(1'b0);
        checks++; if (im.frame_err !== 1'b1) begin failures++; $display("FAIL ferr_set_wins got=%b exp=1", im.frame_err); end
    endtask

    task automatic test_reset_midword();
        do_reset();
        set_ready(1'b0);
        send_word(8'h12, 1'b1, 1'b0);
        bit_cycle(1'b1, 1'b0);
        bit_cycle(1'b0, 1'b0);
        bit_cycle(1'b1, 1'b0);
        bit_cycle(1'b1, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        checks++; if ({im.out_data, im.out_valid, im.busy, im.overrun, im.frame_err} !== 12'h000) begin failures++;
            $display("FAIL midrst_outs got data=%h valid=%b busy=%b ovr=%b ferr=%b exp all 0",
                     im.out_data, im.out_valid, im.busy, im.overrun, im.frame_err); end
        mcnt = 0; lcnt = 0;
        set_ready(1'b1);
        send_word(8'hFF, 1'b1, 1'b0);
        checks++; if (im.out_data !== 8'hFF || il.out_data !== 8'hFF || im.out_valid !== 1'b1) begin failures++;
            $display("FAIL midrst_word got m=%h l=%h valid=%b exp ff/ff/1", im.out_data, il.out_data, im.out_valid); end
        idle(2);
        checks++; if (mcnt !== 1 || im.frame_err !== 1'b0) begin failures++;
            $display("FAIL midrst_count got n=%0d ferr=%b exp 1/0", mcnt, im.frame_err); end
    endtask

    initial begin
        im.serial_in = 1'b0; il.serial_in = 1'b0;
        im.bit_en = 1'b0;    il.bit_en = 1'b0;
        im.frame_start = 1'b0; il.frame_start = 1'b0;
        set_ready(1'b1);
        set_clear(1'b0);
        #1;
        test_reset();
        test_basic();
        test_gaps();
        test_back_to_back();
        test_lsb_first();
        test_overrun();
        test_resync();
        test_reset_midword();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
